// File: rtl/conv_layer_sequencer.sv
// Per-layer controller: for each filter, runs the kernel loader, then the convolution engine.
// It also muxes the shared BRAM read port. Defining SEQ_WATCHDOG_EN adds a wait-state watchdog and a sticky ERROR state.
module conv_layer_sequencer #(
    parameter int BRAM_ADDR_WIDTH  = 10,
    parameter int FILTER_CNT_WIDTH = 4,
    parameter int WDOG_CYCLES      = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [FILTER_CNT_WIDTH-1:0] i_num_filters,
    input  logic [5:0]                  i_kernel_size,
    input  logic [BRAM_ADDR_WIDTH-1:0]  i_kernel_base_addr,
    output logic                        o_kload_start,
    output logic [5:0]                  o_kload_size,
    output logic [BRAM_ADDR_WIDTH-1:0]  o_kload_addr,
    input  logic                        i_kload_done,
    input  logic [BRAM_ADDR_WIDTH-1:0]  i_kload_bram_addr,
    output logic                        o_conv_start,
    input  logic                        i_conv_done,
    input  logic [BRAM_ADDR_WIDTH-1:0]  i_conv_bram_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]  o_bram_addr,
    output logic [1:0]                  o_bram_owner,
    output logic [FILTER_CNT_WIDTH-1:0] o_filter_idx,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_error
);

    if (WDOG_CYCLES < 2) begin : g_bad_wdog
        $error("conv_layer_sequencer: WDOG_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_START,
        S_LOAD_WAIT,
        S_CONV_START,
        S_CONV_WAIT,
        S_NEXT,
        S_DONE
`ifdef SEQ_WATCHDOG_EN
        , S_ERROR
`endif
    } state_t;

    state_t                      state_q, state_d;
    logic [5:0]                  size_q, size_d;
    logic [FILTER_CNT_WIDTH-1:0] count_q, count_d;
    logic [BRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [FILTER_CNT_WIDTH-1:0] idx_q, idx_d;
    logic                        kdone_q, cdone_q;
    logic                        kload_evt, conv_evt;

    assign kload_evt = i_kload_done & ~kdone_q;
    assign conv_evt  = i_conv_done & ~cdone_q;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_hit;

    assign wdog_hit = (wdog_q == WDOG_LAST);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            kdone_q <= 1'b0;
            cdone_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            kdone_q <= i_kload_done;
            cdone_q <= i_conv_done;
`ifdef SEQ_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        count_d = count_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    size_d  = i_kernel_size;
                    count_d = i_num_filters;
                    addr_d  = i_kernel_base_addr;
                    idx_d   = '0;
                    state_d = (i_num_filters == '0) ? S_DONE : S_LOAD_START;
                end
            end
            S_LOAD_START: state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (kload_evt) state_d = S_CONV_START;
`ifdef SEQ_WATCHDOG_EN
                else if (wdog_hit) state_d = S_ERROR;
`endif
            end
            S_CONV_START: state_d = S_CONV_WAIT;
            S_CONV_WAIT: begin
                if (conv_evt) state_d = S_NEXT;
`ifdef SEQ_WATCHDOG_EN
                else if (wdog_hit) state_d = S_ERROR;
`endif
            end
            S_NEXT: begin
                if (idx_q == count_q - FILTER_CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + FILTER_CNT_WIDTH'(1);
                    // Address wraps silently at the top of BRAM.
                    addr_d  = addr_q + BRAM_ADDR_WIDTH'(size_q);
                    state_d = S_LOAD_START;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = state_q;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    // Cleared on entry to a wait state, counts while waiting, holds elsewhere.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_d == S_LOAD_WAIT || state_d == S_CONV_WAIT) && state_d != state_q)
            wdog_d = '0;
        else if (state_q == S_LOAD_WAIT || state_q == S_CONV_WAIT)
            wdog_d = wdog_q + WDOG_W'(1);
    end
`endif

    always_comb begin
        o_kload_start = 1'b0;
        o_conv_start  = 1'b0;
        o_done        = 1'b0;
        o_busy        = (state_q != S_IDLE);
        o_error       = 1'b0;
        o_bram_addr   = '0;
        o_bram_owner  = 2'b00;
        case (state_q)
            S_LOAD_START, S_LOAD_WAIT: begin
                o_kload_start = (state_q == S_LOAD_START);
                o_bram_addr   = i_kload_bram_addr;
                o_bram_owner  = 2'b01;
            end
            S_CONV_START, S_CONV_WAIT: begin
                o_conv_start  = (state_q == S_CONV_START);
                o_bram_addr   = i_conv_bram_addr;
                o_bram_owner  = 2'b10;
            end
            S_DONE: o_done = 1'b1;
`ifdef SEQ_WATCHDOG_EN
            S_ERROR: o_error = 1'b1;
`endif
            default: ;
        endcase
    end

    assign o_kload_size = size_q;
    assign o_kload_addr = addr_q;
    assign o_filter_idx = idx_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (default build, watchdog macro undefined).
module tb_conv_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_filters;
    logic [5:0] kernel_size;
    logic [9:0] base_addr;
    logic       kload_start;
    logic [5:0] kload_size;
    logic [9:0] kload_addr;
    logic       kload_done;
    logic [9:0] kload_bram_addr;
    logic       conv_start;
    logic       conv_done;
    logic [9:0] conv_bram_addr;
    logic [9:0] bram_addr;
    logic [1:0] bram_owner;
    logic [3:0] filter_idx;
    logic       busy;
    logic       done;
    logic       error;

    int errors = 0;
    int checks = 0;
    int kstart_cnt = 0;
    int cstart_cnt = 0;
    int done_cnt = 0;

    conv_layer_sequencer #(
        .BRAM_ADDR_WIDTH(10),
        .FILTER_CNT_WIDTH(4),
        .WDOG_CYCLES(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_num_filters(num_filters),
        .i_kernel_size(kernel_size),
        .i_kernel_base_addr(base_addr),
        .o_kload_start(kload_start),
        .o_kload_size(kload_size),
        .o_kload_addr(kload_addr),
        .i_kload_done(kload_done),
        .i_kload_bram_addr(kload_bram_addr),
        .o_conv_start(conv_start),
        .i_conv_done(conv_done),
        .i_conv_bram_addr(conv_bram_addr),
        .o_bram_addr(bram_addr),
        .o_bram_owner(bram_owner),
        .o_filter_idx(filter_idx),
        .o_busy(busy),
        .o_done(done),
        .o_error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kload_start === 1'b1) kstart_cnt <= kstart_cnt + 1;
        if (conv_start === 1'b1)  cstart_cnt <= cstart_cnt + 1;
        if (done === 1'b1)        done_cnt   <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_filters = '0;
        kernel_size = '0;
        base_addr = '0;
        kload_done = 1'b0;
        conv_done = 1'b0;
        kload_bram_addr = 10'h1AA;
        conv_bram_addr = 10'h055;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_kstart", 32'(kload_start), 32'd0);
        check("rst_owner", 32'(bram_owner), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_kaddr", 32'(kload_addr), 32'd0);
        check("rst_ksize", 32'(kload_size), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Two filters: count=2, size=9, base=100
        num_filters = 4'd2;
        kernel_size = 6'd9;
        base_addr = 10'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f0_kstart", 32'(kload_start), 32'd1);
        check("f0_kaddr", 32'(kload_addr), 32'd100);
        check("f0_idx", 32'(filter_idx), 32'd0);
        check("f0_ksize", 32'(kload_size), 32'd9);
        check("f0_owner_ld", 32'(bram_owner), 32'd1);
        check("f0_busy", 32'(busy), 32'd1);
        tick();
        check("f0_lw_kstart", 32'(kload_start), 32'd0);
        check("f0_lw_bram", 32'(bram_addr), 32'h1AA);
        // start while busy must be ignored
        num_filters = 4'd5;
        kernel_size = 6'd3;
        base_addr = 10'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_size", 32'(kload_size), 32'd9);
        check("busy_start_owner", 32'(bram_owner), 32'd1);
        kload_done = 1'b1;
        tick();
        kload_done = 1'b0;
        check("f0_cstart", 32'(conv_start), 32'd1);
        check("f0_owner_cv", 32'(bram_owner), 32'd2);
        tick();
        check("f0_cw_cstart", 32'(conv_start), 32'd0);
        check("f0_cw_bram", 32'(bram_addr), 32'h055);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("f0_next_owner", 32'(bram_owner), 32'd0);
        check("f0_next_bram", 32'(bram_addr), 32'd0);
        check("f0_next_busy", 32'(busy), 32'd1);
        tick();
        check("f1_kstart", 32'(kload_start), 32'd1);
        check("f1_kaddr", 32'(kload_addr), 32'd109);
        check("f1_idx", 32'(filter_idx), 32'd1);
        check("f1_owner_ld", 32'(bram_owner), 32'd1);
        tick();
        kload_done = 1'b1;
        tick();
        kload_done = 1'b0;
        check("f1_cstart", 32'(conv_start), 32'd1);
        check("f1_owner_cv", 32'(bram_owner), 32'd2);
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("f1_next_done", 32'(done), 32'd0);
        tick();
        check("layer_done", 32'(done), 32'd1);
        check("layer_done_bram", 32'(bram_addr), 32'd0);
        tick();
        check("after_done", 32'(done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
        check("idle_bram", 32'(bram_addr), 32'd0);
        check("cnt_kstart_2f", 32'(kstart_cnt), 32'd2);
        check("cnt_cstart_2f", 32'(cstart_cnt), 32'd2);
        check("cnt_done_2f", 32'(done_cnt), 32'd1);

        // Stale kload_done held high, then address wrap: base=1020, size=9, count=2
        kload_done = 1'b1;
        num_filters = 4'd2;
        kernel_size = 6'd9;
        base_addr = 10'd1020;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("w0_kaddr", 32'(kload_addr), 32'd1020);
        tick();
        tick();
        tick();
        check("stale_cstart", 32'(conv_start), 32'd0);
        check("stale_owner", 32'(bram_owner), 32'd1);
        kload_done = 1'b0;
        tick();
        check("stale_still_ld", 32'(bram_owner), 32'd1);
        kload_done = 1'b1;
        tick();
        kload_done = 1'b0;
        check("w0_cstart", 32'(conv_start), 32'd1);
        tick();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        tick();
        check("wrap_kaddr", 32'(kload_addr), 32'd5);
        check("wrap_idx", 32'(filter_idx), 32'd1);
        tick();
        kload_done = 1'b1;
        tick();
        kload_done = 1'b0;
        tick();
        check("w1_cwait_owner", 32'(bram_owner), 32'd2);

        // Asynchronous reset in CONV_WAIT
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_owner", 32'(bram_owner), 32'd0);
        check("arst_bram", 32'(bram_addr), 32'd0);
        check("arst_kaddr", 32'(kload_addr), 32'd0);
        check("arst_idx", 32'(filter_idx), 32'd0);
        check("arst_ksize", 32'(kload_size), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("arst_no_done", 32'(done_cnt), 32'd1);
        check("arst_idle", 32'(busy), 32'd0);

        // Zero filters
        num_filters = 4'd0;
        kernel_size = 6'd25;
        base_addr = 10'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        tick();
        check("zero_after", 32'(done), 32'd0);
        check("cnt_kstart_all", 32'(kstart_cnt), 32'd4);
        check("cnt_cstart_all", 32'(cstart_cnt), 32'd4);
        check("cnt_done_all", 32'(done_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
